// File: rtl/ntt_stage_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 Cooley-Tukey NTT over one registered butterfly.
// Define NTT_PERF_EN to add the perf_cycles / perf_stalls counters.
module ntt_stage_sequencer #(
    parameter int unsigned LOG_N    = 10,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic [4:0]       stage,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
`ifdef NTT_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls
`endif
);

    localparam int unsigned KW         = LOG_N - 1;
    localparam logic [KW-1:0] KLast     = '1;
    localparam logic [4:0]    SLast     = 5'(LOG_N - 1);
    localparam logic [3:0]    DrainInit = 4'(PIPE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [4:0]    s_q, s_d;
    logic [3:0]    drain_q, drain_d;
    logic          accept;

    logic [PIPE_LAT-1:0] vld_q;
    logic [LOG_N-1:0]    wa_q [PIPE_LAT];
    logic [LOG_N-1:0]    wb_q [PIPE_LAT];

    logic [LOG_N-1:0] k_ext;
    logic [LOG_N-1:0] half;
    logic [LOG_N-1:0] j;
    logic [LOG_N-1:0] g;
    logic [LOG_N-1:0] base_a;
    logic [4:0]       tw_shift;

    // Butterfly k of stage s pairs (g*2*half + j) with its partner half above.
    always_comb begin
        k_ext    = LOG_N'(k_q);
        half     = LOG_N'(1) << s_q;
        j        = k_ext & (half - LOG_N'(1));
        g        = k_ext >> s_q;
        base_a   = (g << (s_q + 5'd1)) | j;
        tw_shift = SLast - s_q;
    end

    assign accept = (state_q == StIdle) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            s_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                k_d = '0;
                s_d = '0;
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (k_q == KLast) begin
                        k_d     = '0;
                        drain_d = DrainInit;
                        state_d = StDrain;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StDrain: begin
                // drain_q reaches 0 on the cycle the stage's last write is on the port.
                if (!stall) begin
                    if (drain_q != 4'd0) begin
                        drain_d = drain_q - 4'd1;
                    end else if (s_q == SLast) begin
                        state_d = StFinish;
                    end else begin
                        s_d     = s_q + 5'd1;
                        k_d     = '0;
                        state_d = StRun;
                    end
                end
            end
            StFinish: begin
                s_d     = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= rd_en;
            wa_q[0]  <= rd_addr_a;
            wb_q[0]  <= rd_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                wa_q[i]  <= wa_q[i-1];
                wb_q[i]  <= wb_q[i-1];
            end
        end
    end

    always_comb begin
        busy      = (state_q == StRun) || (state_q == StDrain);
        done      = (state_q == StFinish);
        stage     = s_q;
        rd_en     = (state_q == StRun) && !stall;
        rd_addr_a = rd_en ? base_a : '0;
        rd_addr_b = rd_en ? (base_a | half) : '0;
        tw_addr   = rd_en ? (j[KW-1:0] << tw_shift) : '0;
        wr_en     = vld_q[PIPE_LAT-1] && !stall;
        wr_addr_a = wr_en ? wa_q[PIPE_LAT-1] : '0;
        wr_addr_b = wr_en ? wb_q[PIPE_LAT-1] : '0;
    end

`ifdef NTT_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] stl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (accept) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (busy) begin
            if (cyc_q != '1) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (stall && (stl_q != '1)) begin
                stl_q <= stl_q + 32'd1;
            end
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_stalls = stl_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Self-checking bench for ntt_stage_sequencer (LOG_N=3, PIPE_LAT=2) against an effective-time model.
module tb_ntt_stage_sequencer;

    localparam int LOG_N    = 3;
    localparam int PIPE_LAT = 2;
    localparam int N        = 1 << LOG_N;
    localparam int HALF     = N / 2;
    localparam int T        = HALF + PIPE_LAT;
    localparam int TOT      = LOG_N * T;
    localparam int WIN      = 30;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic             busy, done, rd_en, wr_en;
    logic [4:0]       stage;
    logic [LOG_N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG_N-2:0] tw_addr;
`ifdef NTT_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    ntt_stage_sequencer #(.LOG_N(LOG_N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
`ifdef NTT_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Butterfly addresses from plain arithmetic: pair index k inside group g of size 2*half.
    function automatic void bfly(input int s, input int k, output int a, output int b,
                                 output int tw);
        int h;
        h  = 1 << s;
        a  = (k / h) * 2 * h + (k % h);
        b  = a + h;
        tw = (k % h) * (1 << (LOG_N - 1 - s));
    endfunction

    // Model: m_e is the 1-based count of non-stalled cycles since acceptance.
    int   m_e = 0;
    bit   m_act = 1'b0;
    int   rel = 0;
    int   done_cnt = 0;
    int   pc_exp = 0;
    int   ps_exp = 0;
    logic lg_rd [64];
    logic lg_wr [64];
    logic lg_done [64];
    int   lg_a [64];
    int   lg_b [64];
    int   lg_tw [64];
    int   lg_wa [64];
    int   lg_wb [64];

    always @(negedge clk) begin : cmp
        logic x_busy, x_done, x_rd, x_wr;
        int   x_stage, x_a, x_b, x_tw, x_wa, x_wb, x_dummy, o, e2;
        x_busy = 1'b0; x_done = 1'b0; x_rd = 1'b0; x_wr = 1'b0;
        x_stage = 0; x_a = 0; x_b = 0; x_tw = 0; x_wa = 0; x_wb = 0; x_dummy = 0;
        if (!rst && m_act) begin
            if (m_e == TOT + 1) begin
                x_done  = 1'b1;
                x_stage = LOG_N - 1;
            end else begin
                x_busy  = 1'b1;
                x_stage = (m_e - 1) / T;
                o       = (m_e - 1) % T;
                if (!stall && o < HALF) begin
                    x_rd = 1'b1;
                    bfly(x_stage, o, x_a, x_b, x_tw);
                end
                e2 = m_e - PIPE_LAT;
                if (!stall && e2 >= 1 && ((e2 - 1) % T) < HALF) begin
                    x_wr = 1'b1;
                    bfly((e2 - 1) / T, (e2 - 1) % T, x_wa, x_wb, x_dummy);
                end
            end
        end
        chk("busy", busy, x_busy);
        chk("done", done, x_done);
        chk("stage", stage, x_stage);
        chk("rd_en", rd_en, x_rd);
        chk("rd_addr_a", rd_addr_a, x_a);
        chk("rd_addr_b", rd_addr_b, x_b);
        chk("tw_addr", tw_addr, x_tw);
        chk("wr_en", wr_en, x_wr);
        chk("wr_addr_a", wr_addr_a, x_wa);
        chk("wr_addr_b", wr_addr_b, x_wb);

        if (done === 1'b1) done_cnt++;
        if (m_act && rel < 64) begin
            lg_rd[rel] = rd_en;   lg_a[rel] = int'(rd_addr_a); lg_b[rel] = int'(rd_addr_b);
            lg_tw[rel] = int'(tw_addr);
            lg_wr[rel] = wr_en;   lg_wa[rel] = int'(wr_addr_a); lg_wb[rel] = int'(wr_addr_b);
            lg_done[rel] = done;
        end

        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1'b1; m_e = 1; rel = 1; pc_exp = 0; ps_exp = 0;
                for (int i = 0; i < 64; i++) begin
                    lg_rd[i] = 1'b0; lg_wr[i] = 1'b0; lg_done[i] = 1'b0;
                    lg_a[i] = 0; lg_b[i] = 0; lg_tw[i] = 0; lg_wa[i] = 0; lg_wb[i] = 0;
                end
            end
        end else begin
            if (m_e <= TOT) begin
                pc_exp++;
                if (stall) ps_exp++;
            end
            if (m_e == TOT + 1) m_act = 1'b0;
            else if (!stall) m_e++;
            rel++;
        end
    end

    // Hand-computed read schedule for N=8, PIPE_LAT=2.
    int lit_cyc [12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    int lit_a   [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b   [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic lit_check(input string tag);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_rd_en_%0d", tag, i), lg_rd[lit_cyc[i]], 1);
            chk($sformatf("%s_rd_a_%0d", tag, i), lg_a[lit_cyc[i]], lit_a[i]);
            chk($sformatf("%s_rd_b_%0d", tag, i), lg_b[lit_cyc[i]], lit_b[i]);
            chk($sformatf("%s_tw_%0d", tag, i), lg_tw[lit_cyc[i]], lit_tw[i]);
        end
        chk({tag, "_no_rd_5"}, lg_rd[5], 0);
        chk({tag, "_no_rd_6"}, lg_rd[6], 0);
        chk({tag, "_done_18"}, lg_done[18], 0);
        chk({tag, "_done_19"}, lg_done[19], 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tx(input int st_from, input int st_len, input int re_start,
                          input int rst_at, input bit acc_stall, output int ndone);
        int base;
        base  = done_cnt;
        start = 1'b1;
        stall = acc_stall;
        tick();
        start = 1'b0;
        for (int c = 1; c <= WIN; c++) begin
            stall = (c >= st_from) && (c < st_from + st_len);
            start = (c == re_start);
            rst   = (rst_at > 0) && (c >= rst_at) && (c < rst_at + 2);
            tick();
        end
        stall = 1'b0;
        start = 1'b0;
        rst   = 1'b0;
        ndone = done_cnt - base;
    endtask

    initial begin : drive
        int nd;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        tick();

        run_tx(-1, 0, -1, -1, 1'b0, nd);
        chk("plain_done_count", nd, 1);
        lit_check("plain");

        run_tx(5, 3, -1, -1, 1'b0, nd);
        chk("stall_done_count", nd, 1);
        chk("stall_wr_6", lg_wr[6], 0);
        chk("stall_wr_9", lg_wr[9], 1);
        chk("stall_wa_9", lg_wa[9], 6);
        chk("stall_wb_9", lg_wb[9], 7);
        chk("stall_done_19", lg_done[19], 0);
        chk("stall_done_22", lg_done[22], 1);
`ifdef NTT_PERF_EN
        chk("perf_cycles_model", perf_cycles, pc_exp);
        chk("perf_stalls_model", perf_stalls, ps_exp);
        chk("perf_cycles_21", perf_cycles, 21);
        chk("perf_stalls_3", perf_stalls, 3);
`endif

        run_tx(-1, 0, 10, -1, 1'b1, nd);
        chk("restart_done_count", nd, 1);
        lit_check("restart");
        run_tx(-1, 0, -1, -1, 1'b0, nd);
        chk("after_restart_done_count", nd, 1);
        lit_check("after_restart");

        run_tx(-1, 0, -1, 8, 1'b0, nd);
        chk("reset_done_count", nd, 0);
        run_tx(-1, 0, -1, -1, 1'b0, nd);
        chk("post_reset_done_count", nd, 1);
        lit_check("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
